regfile_sequencer: RTL and testbench

//  Operand-fetch / execute / write-back sequencer sitting directly upstream of the 16x32 register file.

---
 rtl/regfile_sequencer.sv | 146 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Fetch / execute / write-back sequencer for the 16x32 register file. It runs one instruction at a time, and each instruction occupies it for 4 cycles.
// Optional condition flags (flag_z/flag_c/flag_n) are included when SEQ_FLAGS_EN is defined.
module regfile_sequencer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  // instr_*: an instruction transfers on a rising edge where instr_valid && instr_ready.
  // instr_ready is high only in IDLE. The fields need to be stable only at that edge.
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [15:0]       instr_imm,
  output logic [ADDR_W-1:0] rf_addr0,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic              rf_ctrw,
  output logic [DATA_W-1:0] rf_in,
  input  logic [DATA_W-1:0] rf_out0,
  input  logic [DATA_W-1:0] rf_out1,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
`ifdef SEQ_FLAGS_EN
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
`endif
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

  localparam logic [ADDR_W-1:0] RD_LIMIT = ADDR_W'(NUM_REGS);

  state_t              state;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [15:0]         imm_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                op_illegal;
  logic                err_next;

  assign state_dbg = state;

  // Illegal opcodes leave alu_res at zero, which is the required result for them.
  always_comb begin
    alu_res    = '0;
    alu_carry  = 1'b0;
    op_illegal = 1'b0;
    case (op_q)
      4'd0: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      4'd1: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      4'd2: alu_res = a_q & b_q;
      4'd3: alu_res = a_q | b_q;
      4'd4: alu_res = a_q ^ b_q;
      4'd5: alu_res = a_q << b_q[4:0];
      4'd6: alu_res = a_q >> b_q[4:0];
      4'd7: alu_res = a_q;
      4'd8: alu_res = DATA_W'(imm_q);
      default: op_illegal = 1'b1;
    endcase
    err_next = op_illegal | (rd_q >= RD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rf_addr0    <= '0;
      rf_addr1    <= '0;
      rf_ctrw     <= 1'b0;
      rf_in       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
`ifdef SEQ_FLAGS_EN
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_n      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            imm_q       <= instr_imm;
            rf_addr0    <= instr_rs;
            rf_addr1    <= instr_rt;
            instr_ready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          a_q   <= rf_out0;
          b_q   <= rf_out1;
          state <= EXEC;
        end
        EXEC: begin
          // The write-back outputs are set up here, so in WRITE they come directly from flops.
          result   <= alu_res;
          rf_in    <= alu_res;
          rf_addr0 <= rd_q;
          rf_addr1 <= '0;
          rf_ctrw  <= ~err_next;
          done     <= 1'b1;
          err      <= err_next;
`ifdef SEQ_FLAGS_EN
          flag_z   <= ~op_illegal & (alu_res == '0);
          flag_n   <= ~op_illegal & alu_res[DATA_W-1];
          flag_c   <= alu_carry;
`endif
          state    <= WRITE;
        end
        WRITE: begin
          rf_ctrw     <= 1'b0;
          rf_in       <= '0;
          rf_addr0    <= '0;
          done        <= 1'b0;
          err         <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer. It models the register file, and a scoreboard queue predicts each write-back.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [7:0]  instr_rd = '0;
  logic [7:0]  instr_rs = '0;
  logic [7:0]  instr_rt = '0;
  logic [15:0] instr_imm = '0;
  logic [7:0]  rf_addr0, rf_addr1;
  logic        rf_ctrw;
  logic [31:0] rf_in, rf_out0, rf_out1;
  logic        done, err;
  logic [31:0] result;
  logic [1:0]  state_dbg;
`ifdef SEQ_FLAGS_EN
  logic        flag_z, flag_c, flag_n;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [31:0] rf     [16];
  logic [31:0] exp_rf [16];
  // Entry layout: {write_expected, err, rd[7:0], result[31:0]}
  logic [41:0] exp_q[$];

  regfile_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_ctrw(rf_ctrw),
    .rf_in(rf_in), .rf_out0(rf_out0), .rf_out1(rf_out1),
    .done(done), .err(err), .result(result),
`ifdef SEQ_FLAGS_EN
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Register file stand-in: reads are combinational, writes commit on the clock edge, and an out-of-range read returns 0.
  always_comb rf_out0 = (rf_addr0 < 8'd16) ? rf[rf_addr0[3:0]] : 32'h0;
  always_comb rf_out1 = (rf_addr1 < 8'd16) ? rf[rf_addr1[3:0]] : 32'h0;
  always @(posedge clk) if (rf_ctrw && rf_addr0 < 8'd16) rf[rf_addr0[3:0]] <= rf_in;

  // Monitor: check every retire against the scoreboard, and flag any write strobe outside a retire.
  always @(negedge clk) begin
    logic [41:0] e;
    if (mon_en) begin
      if (done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: done=1 with no instruction outstanding");
        end else begin
          e = exp_q.pop_front();
          total++;
          if ({rf_ctrw, err} !== e[41:40]) begin
            bad++;
            $display("FAIL retire_ctrl: ctrw,err=%b%b required=%b%b", rf_ctrw, err, e[41], e[40]);
          end
          if (e[41]) begin
            total++;
            if (rf_addr0 !== e[39:32] || rf_in !== e[31:0]) begin
              bad++;
              $display("FAIL write_data: addr=%0d data=%h required addr=%0d data=%h",
                       rf_addr0, rf_in, e[39:32], e[31:0]);
            end
          end
          total++;
          if (result !== e[31:0]) begin
            bad++;
            $display("FAIL result: got=%h required=%h", result, e[31:0]);
          end
        end
      end else begin
        total++;
        if (rf_ctrw !== 1'b0) begin
          bad++;
          $display("FAIL stray_write: rf_ctrw=%b outside retire, required=0", rf_ctrw);
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    rf[idx]     = v;
    exp_rf[idx] = v;
  endtask

  task automatic push_expected(input logic [3:0] op, input logic [7:0] rd, input logic [7:0] rs,
                               input logic [7:0] rt, input logic [15:0] imm);
    logic [31:0] a, b, r;
    logic ill, e, wr;
    a = (rs < 8'd16) ? exp_rf[rs[3:0]] : 32'h0;
    b = (rt < 8'd16) ? exp_rf[rt[3:0]] : 32'h0;
    ill = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = a;
      4'd8: r = {16'h0, imm};
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
    e  = ill || (rd >= 8'd16);
    wr = !e;
    if (wr) exp_rf[rd[3:0]] = r;
    exp_q.push_back({wr, e, rd, r});
  endtask

  // Offer one instruction and return #1 after the edge that accepts it.
  task automatic issue(input logic [3:0] op, input logic [7:0] rd, input logic [7:0] rs,
                       input logic [7:0] rt, input logic [15:0] imm, input bit track);
    int budget = 0;
    @(negedge clk);
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: instr_ready=%b required=1", instr_ready);
    end else if (track) begin
      push_expected(op, rd, rs, rt, imm);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: outstanding=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (instr_ready !== 1'b1 || rf_ctrw !== 1'b0 || done !== 1'b0 || result !== 32'h0 ||
          err !== 1'b0 || state_dbg !== 2'd0) begin
        bad++;
        $display("FAIL reset_idle: ready=%b ctrw=%b done=%b err=%b result=%h state=%0d required 1 0 0 0 0 0",
                 instr_ready, rf_ctrw, done, err, result, state_dbg);
      end
    end
  endtask

  task automatic test_add();
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    preload(1, 32'd5);
    preload(2, 32'd3);
    issue(4'd0, 8'd4, 8'd1, 8'd2, 16'h0, 1'b1);
    @(negedge clk);
    total++;
    if (rf_addr0 !== 8'd1 || rf_addr1 !== 8'd2 || instr_ready !== 1'b0 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL add_fetch: addr0=%0d addr1=%0d ready=%b state=%0d required 1 2 0 1",
               rf_addr0, rf_addr1, instr_ready, state_dbg);
    end
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b0 || done !== 1'b0 || rf_ctrw !== 1'b0) begin
      bad++;
      $display("FAIL add_exec: ready=%b done=%b ctrw=%b required 0 0 0", instr_ready, done, rf_ctrw);
    end
    @(negedge clk);
    total++;
    if (rf_ctrw !== 1'b1 || rf_addr0 !== 8'd4 || rf_in !== 32'd8 || done !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL add_write: ctrw=%b addr0=%0d in=%h done=%b err=%b required 1 4 8 1 0",
               rf_ctrw, rf_addr0, rf_in, done, err);
    end
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1 || rf[4] !== 32'd8) begin
      bad++;
      $display("FAIL add_commit: ready=%b r4=%h required 1 8", instr_ready, rf[4]);
    end
    wait_drain();
  endtask

  task automatic test_sub();
    int k = 0;
    preload(1, 32'd0);
    preload(2, 32'd1);
    issue(4'd1, 8'd3, 8'd1, 8'd2, 16'h0, 1'b1);
    @(negedge clk);
    while (done !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done !== 1'b1 || rf_in !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sub_result: done=%b in=%h required 1 ffffffff", done, rf_in);
    end
`ifdef SEQ_FLAGS_EN
    total++;
    if ({flag_c, flag_n, flag_z} !== 3'b110) begin
      bad++;
      $display("FAIL sub_flags: c,n,z=%b%b%b required=110", flag_c, flag_n, flag_z);
    end
`endif
    wait_drain();
  endtask

  task automatic test_errors();
    issue(4'd8, 8'd20, 8'd0, 8'd0, 16'h1234, 1'b1);
    wait_drain();
    issue(4'd12, 8'd2, 8'd1, 8'd1, 16'h0, 1'b1);
    wait_drain();
    total++;
    if (result !== 32'h0 || rf[2] !== 32'd1) begin
      bad++;
      $display("FAIL illegal_no_write: result=%h r2=%h required 0 1", result, rf[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3];
    logic [7:0] rds [3];
    logic [7:0] rss [3];
    logic [7:0] rts [3];
    int acc [3];
    int n = 0;
    int t = 0;
    preload(1, 32'd5);
    preload(2, 32'd3);
    ops[0] = 4'd0; rds[0] = 8'd6; rss[0] = 8'd1; rts[0] = 8'd2;
    ops[1] = 4'd4; rds[1] = 8'd7; rss[1] = 8'd6; rts[1] = 8'd1;
    ops[2] = 4'd5; rds[2] = 8'd8; rss[2] = 8'd7; rts[2] = 8'd2;
    @(negedge clk);
    instr_op = ops[0]; instr_rd = rds[0]; instr_rs = rss[0]; instr_rt = rts[0]; instr_imm = '0;
    instr_valid = 1'b1;
    while (n < 3 && t < 40) begin
      if (instr_ready === 1'b1) begin
        push_expected(ops[n], rds[n], rss[n], rts[n], 16'h0);
        acc[n] = t;
        n++;
        @(posedge clk); #1;
        if (n < 3) begin
          instr_op = ops[n]; instr_rd = rds[n]; instr_rs = rss[n]; instr_rt = rts[n];
        end else begin
          instr_valid = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    instr_valid = 1'b0;
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL b2b_count: accepted=%0d required=3", n);
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (acc[i] - acc[i-1] != 4) begin
          bad++;
          $display("FAIL b2b_spacing: gap=%0d required=4", acc[i] - acc[i-1]);
        end
      end
    end
    wait_drain();
    total++;
    if (rf[8] !== 32'd104) begin
      bad++;
      $display("FAIL b2b_chain: r8=%h required=00000068", rf[8]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r5_before;
    r5_before = exp_rf[5];
    issue(4'd0, 8'd5, 8'd1, 8'd2, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (state_dbg !== 2'd2) begin
      bad++;
      $display("FAIL rst_in_exec: state=%0d required=2", state_dbg);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1 || result !== 32'h0) begin
      bad++;
      $display("FAIL rst_release: ready=%b result=%h required 1 0", instr_ready, result);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || rf_ctrw !== 1'b0) begin
        bad++;
        $display("FAIL rst_abort: done=%b ctrw=%b required 0 0", done, rf_ctrw);
      end
    end
    total++;
    if (rf[5] !== r5_before) begin
      bad++;
      $display("FAIL rst_no_write: r5=%h required=%h", rf[5], r5_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) preload(i, $urandom());
    for (int i = 0; i < 12; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 17)), 8'($urandom_range(0, 17)),
            8'($urandom_range(0, 17)), 16'($urandom_range(0, 65535)), 1'b1);
      wait_drain();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    test_reset();
    test_add();
    test_sub();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rf[i] !== exp_rf[i]) begin
        bad++;
        $display("FAIL final_reg%0d: got=%h required=%h", i, rf[i], exp_rf[i]);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
